// File: rtl/line_arbiter_if.sv
// Line-request bus between N requesters, the arbiter, and the single downstream line port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's.
interface line_arbiter_if #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LINE_W    = 256
);
    logic [NUM_PORTS*ADDR_W-1:0] req_address;
    logic [NUM_PORTS*LINE_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]        req_read;
    logic [NUM_PORTS-1:0]        req_write;
    logic [LINE_W-1:0]           req_rdata;
    logic [NUM_PORTS-1:0]        req_resp;
    logic [ADDR_W-1:0]           mem_address;
    logic [LINE_W-1:0]           mem_wdata;
    logic                        mem_read;
    logic                        mem_write;
    logic [LINE_W-1:0]           mem_rdata;
    logic                        mem_resp;

    modport slave (
        input  req_address, req_wdata, req_read, req_write, mem_rdata, mem_resp,
        output req_rdata, req_resp, mem_address, mem_wdata, mem_read, mem_write
    );

    modport master (
        output req_address, req_wdata, req_read, req_write, mem_rdata, mem_resp,
        input  req_rdata, req_resp, mem_address, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/line_arbiter.sv
// N-port cache-line arbiter: fixed-priority or round-robin with a low-priority class;
// the winning request is latched at grant so the downstream access is immune to requester changes.
module line_arbiter #(
    parameter int unsigned          NUM_PORTS   = 3,
    parameter int unsigned          ADDR_W      = 32,
    parameter int unsigned          LINE_W      = 256,
    parameter int unsigned          RR_MODE     = 1,
    parameter logic [NUM_PORTS-1:0] LOWPRI_MASK = 3'b100
) (
    input  logic                          clk,
    input  logic                          rst,
    line_arbiter_if.slave                 bus,
    output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
    output logic                          busy
);
    localparam int unsigned ID_W = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, state_next;
    logic [NUM_PORTS-1:0] pending, unmasked, eligible;
    logic [ID_W-1:0]      winner, rr_ptr, grant_q;
    logic                 win_valid;
    logic                 grant_c, finish_c;
    logic [NUM_PORTS-1:0] resp_c;
    logic [ADDR_W-1:0]    address_q;
    logic [LINE_W-1:0]    wdata_q;
    logic                 read_q, write_q, busy_q;

    // Eligible set prefers unmasked requesters; scan starts at rr_ptr in round-robin mode.
    always_comb begin
        int unsigned base;
        int unsigned idx;
        pending   = bus.req_read | bus.req_write;
        unmasked  = pending & ~LOWPRI_MASK;
        eligible  = (|unmasked) ? unmasked : (pending & LOWPRI_MASK);
        winner    = '0;
        win_valid = 1'b0;
        base      = (RR_MODE != 0) ? 32'(rr_ptr) : 32'd0;
        idx       = 32'd0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = base + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!win_valid && eligible[idx[ID_W-1:0]]) begin
                winner    = idx[ID_W-1:0];
                win_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state plus the zero-latency completion pulse back to the granted requester.
    always_comb begin
        state_next = state;
        grant_c    = 1'b0;
        finish_c   = 1'b0;
        resp_c     = '0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    grant_c    = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_resp) begin
                    finish_c   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (finish_c && !rst) resp_c[grant_q] = 1'b1;
    end

    // Holding registers for the granted transaction and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q   <= '0;
            address_q <= '0;
            wdata_q   <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            if (grant_c) begin
                grant_q   <= winner;
                address_q <= bus.req_address[32'(winner)*ADDR_W +: ADDR_W];
                wdata_q   <= bus.req_wdata[32'(winner)*LINE_W +: LINE_W];
                write_q   <= bus.req_write[winner];
                read_q    <= ~bus.req_write[winner];
                busy_q    <= 1'b1;
            end
            if (finish_c) begin
                read_q  <= 1'b0;
                write_q <= 1'b0;
                busy_q  <= 1'b0;
                rr_ptr  <= (grant_q == ID_W'(NUM_PORTS - 1)) ? '0 : grant_q + ID_W'(1);
            end
        end
    end

    assign bus.mem_address = address_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_read    = read_q;
    assign bus.mem_write   = write_q;
    assign bus.req_resp    = resp_c;
    assign bus.req_rdata   = bus.mem_rdata;
    assign grant_id        = grant_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_line_arbiter.sv
// Bench for line_arbiter: directed scenarios plus random traffic against a transaction-level model,
// and a second fixed-priority instance exercised with a short directed sequence.
module tb_line_arbiter;
    localparam int unsigned N  = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;
    localparam int unsigned IW = 2;
    localparam int unsigned RR = 1;
    localparam logic [N-1:0] MASK = 3'b100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [IW-1:0] gid, gid_fp;
    logic          busy, busy_fp;

    line_arbiter_if #(.NUM_PORTS(N), .ADDR_W(AW), .LINE_W(LW)) bus ();
    line_arbiter_if #(.NUM_PORTS(N), .ADDR_W(AW), .LINE_W(LW)) bus_fp ();

    line_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1), .LOWPRI_MASK(MASK)) dut (
        .clk(clk), .rst(rst), .bus(bus), .grant_id(gid), .busy(busy));

    line_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(0), .LOWPRI_MASK(3'b000)) dut_fp (
        .clk(clk), .rst(rst), .bus(bus_fp), .grant_id(gid_fp), .busy(busy_fp));

    // Requester and memory stimulus for the main instance
    logic [AW-1:0] r_addr  [N];
    logic [LW-1:0] r_wdata [N];
    logic [N-1:0]  r_read, r_write;
    logic          m_resp;
    logic [LW-1:0] m_rdata;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.req_address[i*AW +: AW] = r_addr[i];
            bus.req_wdata[i*LW +: LW]   = r_wdata[i];
        end
        bus.req_read  = r_read;
        bus.req_write = r_write;
        bus.mem_resp  = m_resp;
        bus.mem_rdata = m_rdata;
    end

    // Reference model: 0 = waiting for a request, 1 = access in flight, 2 = post-completion gap
    int            m_phase = 0;
    int            m_grant = 0;
    int            m_rr    = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [LW-1:0] m_wdata = '0;
    logic          m_wr    = 1'b0;
    int            served  = -1;
    logic [N-1:0]  obs_resp;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Winner = eligible port at the smallest circular distance from the start index.
    function automatic int pick(input logic [N-1:0] pend, input int start);
        logic [N-1:0] elig;
        int best  = -1;
        int bestd = N + 1;
        elig = pend & ~MASK;
        if (elig == '0) elig = pend & MASK;
        for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
                int d = (i - start + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_edge();
        int w;
        if (rst) begin
            m_phase = 0; m_rr = 0; m_grant = 0; m_addr = '0; m_wdata = '0; m_wr = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    w = pick(r_read | r_write, (RR != 0) ? m_rr : 0);
                    if (w >= 0) begin
                        m_grant = w; m_addr = r_addr[w]; m_wdata = r_wdata[w];
                        m_wr = r_write[w]; m_phase = 1;
                    end
                end
                1: if (m_resp) begin
                    m_rr = (m_grant + 1) % N;
                    m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    // One clock: check the completion path with the current inputs, clock, then check held outputs.
    task automatic cycle();
        logic [N-1:0] exp_resp;
        exp_resp = '0;
        #1;
        served = -1;
        if (m_phase == 1 && m_resp && !rst) begin
            exp_resp[m_grant] = 1'b1;
            served = m_grant;
        end
        obs_resp = bus.req_resp;
        chk("req_resp", LW'(bus.req_resp), LW'(exp_resp));
        if (served >= 0) chk("req_rdata", bus.req_rdata, m_rdata);
        @(posedge clk);
        model_edge();
        #1;
        chk("grant_id",    LW'(gid),             LW'(m_grant));
        chk("busy",        LW'(busy),            LW'(m_phase == 1));
        chk("mem_read",    LW'(bus.mem_read),    LW'(m_phase == 1 && !m_wr));
        chk("mem_write",   LW'(bus.mem_write),   LW'(m_phase == 1 && m_wr));
        chk("mem_address", LW'(bus.mem_address), LW'(m_addr));
        chk("mem_wdata",   bus.mem_wdata,        m_wdata);
    endtask

    // Arbitrate, hold the access for lat cycles, complete, then the gap cycle.
    // drop: 0 keep requests, 1 drop the served port, 2 drop every port.
    task automatic serve(input int lat, input int drop, output int g);
        cycle();
        g = gid;
        repeat (lat - 1) cycle();
        m_resp = 1'b1;
        m_rdata = rnd_line();
        cycle();
        m_resp = 1'b0;
        if (drop == 2) begin
            r_read = '0; r_write = '0;
        end else if (drop == 1 && served >= 0) begin
            r_read[served] = 1'b0; r_write[served] = 1'b0;
        end
        cycle();
    endtask

    task automatic fp_txn(output int g, output logic [N-1:0] rs);
        int t = 0;
        while (!(bus_fp.mem_read || bus_fp.mem_write) && t < 20) begin
            @(posedge clk); #1; t++;
        end
        chk("fp_grant_wait", LW'(t < 20), LW'(1));
        g = gid_fp;
        bus_fp.mem_resp = 1'b1;
        #1;
        rs = bus_fp.req_resp;
        @(posedge clk); #1;
        bus_fp.mem_resp = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int seq [5];
        logic [N-1:0] rs;
        int k;

        rst = 1'b1; r_read = '0; r_write = '0; m_resp = 1'b0; m_rdata = '0;
        for (int i = 0; i < N; i++) begin r_addr[i] = '0; r_wdata[i] = '0; end
        bus_fp.req_address = '0; bus_fp.req_wdata = '0; bus_fp.req_read = '0;
        bus_fp.req_write = '0; bus_fp.mem_resp = 1'b0; bus_fp.mem_rdata = '0;

        repeat (2) cycle();
        rst = 1'b0;
        cycle();

        // Single read from port 1, completion four cycles after grant
        r_read[1] = 1'b1; r_addr[1] = 32'h0000_1040;
        cycle();
        repeat (3) cycle();
        m_resp = 1'b1; m_rdata = rnd_line();
        cycle();
        chk("t1_resp", LW'(obs_resp), LW'(3'b010));
        m_resp = 1'b0; r_read[1] = 1'b0;
        cycle();
        chk("t1_busy_low", LW'(busy), LW'(0));

        // Low-priority port 2 yields to port 1 even with the pointer at 2, then alone wins at once
        r_read[1] = 1'b1; r_addr[1] = 32'h0000_3000;
        r_read[2] = 1'b1; r_addr[2] = 32'h0000_4000;
        serve(1, 1, g); chk("lp_first", LW'(g), LW'(1));
        serve(1, 1, g); chk("lp_second", LW'(g), LW'(2));
        r_read[2] = 1'b1; r_addr[2] = 32'h0000_5000;
        serve(1, 1, g); chk("lp_alone", LW'(g), LW'(2));

        // Round robin with ports 0 and 1 continuously requesting, ending with a wrap from 2 to 0
        r_read[0] = 1'b1; r_addr[0] = 32'h0000_0100;
        r_read[1] = 1'b1; r_addr[1] = 32'h0000_0180;
        for (int i = 0; i < 5; i++) serve(2, (i == 4) ? 2 : 0, seq[i]);
        chk("rr_0", LW'(seq[0]), LW'(0));
        chk("rr_1", LW'(seq[1]), LW'(1));
        chk("rr_2", LW'(seq[2]), LW'(0));
        chk("rr_3", LW'(seq[3]), LW'(1));
        chk("rr_wrap", LW'(seq[4]), LW'(0));

        // Write with requester inputs scrambled during the access
        r_write[0] = 1'b1; r_addr[0] = 32'h0000_0200; r_wdata[0] = {8{32'hA5A5_A5A5}};
        cycle();
        r_addr[0] = 32'h0000_0BAD; r_wdata[0] = rnd_line();
        repeat (2) cycle();
        chk("wr_addr_hold", LW'(bus.mem_address), LW'(32'h0000_0200));
        chk("wr_data_hold", bus.mem_wdata, {8{32'hA5A5_A5A5}});
        chk("wr_is_write", LW'(bus.mem_write), LW'(1));
        m_resp = 1'b1;
        cycle();
        m_resp = 1'b0; r_write[0] = 1'b0;
        cycle();

        // Read-and-write on one port issues the write
        r_read[2] = 1'b1; r_write[2] = 1'b1; r_addr[2] = 32'h0000_0700; r_wdata[2] = rnd_line();
        cycle();
        chk("rw_write", LW'(bus.mem_write), LW'(1));
        chk("rw_no_read", LW'(bus.mem_read), LW'(0));
        m_resp = 1'b1; cycle(); m_resp = 1'b0;
        r_read[2] = 1'b0; r_write[2] = 1'b0;
        cycle();

        // Reset during an access abandons it silently; the held request is granted again
        r_read[1] = 1'b1; r_addr[1] = 32'h0000_0900;
        repeat (2) cycle();
        rst = 1'b1; m_resp = 1'b1;
        cycle();
        chk("rst_no_resp", LW'(obs_resp), LW'(0));
        chk("rst_read_low", LW'(bus.mem_read), LW'(0));
        chk("rst_busy_low", LW'(busy), LW'(0));
        rst = 1'b0; m_resp = 1'b0;
        serve(2, 1, g); chk("rst_regrant", LW'(g), LW'(1));

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (served == i) begin
                    r_read[i] = 1'b0; r_write[i] = 1'b0;
                end else if (!(r_read[i] || r_write[i])) begin
                    if ($urandom % 4 == 0) begin
                        k = int'($urandom % 8);
                        r_addr[i]  = $urandom;
                        r_wdata[i] = rnd_line();
                        r_write[i] = (k < 3) || (k == 7);
                        r_read[i]  = (k >= 3);
                    end
                end else if (m_phase == 1 && m_grant == i && $urandom % 6 == 0) begin
                    r_addr[i]  = $urandom;
                    r_wdata[i] = rnd_line();
                end
            end
            m_resp  = (m_phase == 1) ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
            m_rdata = rnd_line();
            rst     = ($urandom % 150 == 0);
            cycle();
        end
        rst = 1'b0; m_resp = 1'b0; r_read = '0; r_write = '0;
        repeat (4) cycle();

        // Fixed priority: port 0 wins while it keeps requesting; port 1 only after it drops
        bus_fp.req_read = 3'b011;
        for (int i = 0; i < 3; i++) begin
            fp_txn(g, rs);
            chk("fp_grant0", LW'(g), LW'(0));
            chk("fp_resp0", LW'(rs), LW'(3'b001));
        end
        bus_fp.req_read = 3'b010;
        fp_txn(g, rs);
        chk("fp_grant1", LW'(g), LW'(1));
        chk("fp_resp1", LW'(rs), LW'(3'b010));
        bus_fp.req_read = '0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
